// File: rtl/ts_channel_monitor.sv
// ts_channel_monitor: MPEG2-TS sync tracker with windowed error counter.
// Ports: clk, rstn, ts_valid, ts_data, reset_timer -> locked, signal_present, error_count.
module ts_channel_monitor #(
  parameter int PKT_LEN         = 188,
  parameter int LOCK_COUNT      = 3,
  parameter int UNLOCK_COUNT    = 3,
  parameter int SILENCE_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ts_valid,
  input  logic [7:0]  ts_data,
  input  logic [19:0] reset_timer,
  output logic        locked,
  output logic        signal_present,
  output logic [7:0]  error_count
);

  localparam int IW = $clog2(PKT_LEN);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(UNLOCK_COUNT + 1);
  localparam int SW = $clog2(SILENCE_TIMEOUT + 1);

  localparam logic [IW-1:0] IDX_LAST = IW'(PKT_LEN - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT);
  localparam logic [GW-1:0] GOOD_ONE = GW'(1);
  localparam logic [MW-1:0] MISS_MAX = MW'(UNLOCK_COUNT);
  localparam logic [SW-1:0] SIL_MAX  = SW'(SILENCE_TIMEOUT);
  localparam logic [7:0]    SYNC     = 8'h47;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_t;

  state_t        state_q, state_n;
  logic [IW-1:0] idx_q, idx_n, idx_adv;
  logic [GW-1:0] good_q, good_n;
  logic [MW-1:0] miss_q, miss_n;
  logic [SW-1:0] sil_q, sil_n;
  logic [19:0]   win_q, win_n;
  logic [7:0]    err_q, err_n;
  logic          locked_q, present_q;
  logic          sync_ok;
  logic          inc;
  logic          clr;

  assign sync_ok = (ts_data == SYNC);
  assign idx_adv = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    good_n  = good_q;
    miss_n  = miss_q;
    inc     = 1'b0;
    if (ts_valid) begin
      unique case (state_q)
        HUNT: begin
          if (sync_ok) begin
            state_n = VERIFY;
            idx_n   = IDX_ONE;
            good_n  = GOOD_ONE;
          end
        end
        VERIFY: begin
          idx_n = idx_adv;
          if (idx_q == '0) begin
            if (sync_ok) begin
              good_n = good_q + 1'b1;
              if (good_n == GOOD_MAX) begin
                state_n = LOCKED;
                miss_n  = '0;
              end
            end else begin
              // The bad byte is dropped, not re-tried as a sync.
              state_n = HUNT;
              idx_n   = '0;
              good_n  = '0;
            end
          end
        end
        LOCKED: begin
          idx_n = idx_adv;
          if (idx_q == '0) begin
            if (sync_ok) begin
              miss_n = '0;
            end else begin
              miss_n = miss_q + 1'b1;
              inc    = 1'b1;
              if (miss_n == MISS_MAX) begin
                state_n = HUNT;
                idx_n   = '0;
                good_n  = '0;
                miss_n  = '0;
              end
            end
          end else if (idx_q == IDX_ONE) begin
            inc = ts_data[7];
          end
        end
        default: begin
          state_n = HUNT;
          idx_n   = '0;
          good_n  = '0;
          miss_n  = '0;
        end
      endcase
    end
    if (ts_valid) begin
      sil_n = '0;
    end else if (sil_q == SIL_MAX) begin
      sil_n = sil_q;
    end else begin
      sil_n = sil_q + 1'b1;
    end
    // A silent stream forces a fresh acquisition.
    if (sil_n == SIL_MAX) begin
      state_n = HUNT;
      idx_n   = '0;
      good_n  = '0;
      miss_n  = '0;
    end
  end

  always_comb begin
    clr   = 1'b0;
    win_n = '0;
    if (reset_timer != '0) begin
      // >= so a lowered window still wraps promptly.
      if (win_q >= reset_timer - 20'd1) begin
        clr = 1'b1;
      end else begin
        win_n = win_q + 20'd1;
      end
    end
    if (clr) begin
      err_n = {7'd0, inc};
    end else if (inc && (err_q != 8'hFF)) begin
      err_n = err_q + 8'd1;
    end else begin
      err_n = err_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= HUNT;
      idx_q     <= '0;
      good_q    <= '0;
      miss_q    <= '0;
      sil_q     <= '0;
      win_q     <= '0;
      err_q     <= '0;
      locked_q  <= 1'b0;
      present_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      good_q    <= good_n;
      miss_q    <= miss_n;
      sil_q     <= sil_n;
      win_q     <= win_n;
      err_q     <= err_n;
      locked_q  <= (state_n == LOCKED);
      present_q <= (state_n == LOCKED) && (sil_n < SIL_MAX);
    end
  end

  assign locked         = locked_q;
  assign signal_present = present_q;
  assign error_count    = err_q;

endmodule

// File: doc/ts_channel_monitor.md
# ts_channel_monitor

Per-channel MPEG2-TS input monitor for the QoS control path. One instance per input channel (four total) acquires and tracks 188-byte packet sync on a byte stream. It counts sync and transport errors over a software-programmed window and reports per-channel `signal_present` and `error_count`. These outputs feed the `signal_present[n]` and `error_count_chN` inputs of the memory-mapped status registers and the channel-selection logic.

## Interface
Parameters:
- `PKT_LEN`, 188: bytes per TS packet.
- `LOCK_COUNT`, 3: consecutive correct sync bytes required to declare lock.
- `UNLOCK_COUNT`, 3: consecutive missed sync bytes that drop lock.
- `SILENCE_TIMEOUT`, 65535: idle clocks without `ts_valid` before signal is declared absent.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `ts_valid`  in  1  `ts_data` is valid this cycle.
- `ts_data`  in  8  TS byte stream.
- `reset_timer`  in  20  error-window length in clocks; 0 disables window clearing.
- `locked`  out  1  sync FSM is in LOCKED.
- `signal_present`  out  1  locked and stream not silent.
- `error_count`  out  8  saturating error count for the current window.

## Operation
- Only bytes with `ts_valid`=1 are examined. `byte_idx` runs 0..`PKT_LEN`-1, where index 0 is the expected sync position, and advances only on valid bytes.
- FSM states: HUNT, VERIFY, LOCKED.
  - **HUNT:**
    - A valid byte equal to 0x47 moves the FSM to VERIFY, with `byte_idx`=1 and `good`=1.
    - Any other byte keeps the FSM in HUNT.
  - **VERIFY:** at `byte_idx`=0:
    - If the byte is 0x47, `good` increments.
    - When `good` reaches `LOCK_COUNT`, the FSM moves to LOCKED with `miss`=0.
    - If the byte is not 0x47, the FSM returns to HUNT. The mismatching byte is not re-examined as a new sync candidate.
  - **LOCKED:**
    - At `byte_idx`=0:
      - If the byte is 0x47, `miss` clears.
      - Otherwise, `miss` increments and `error_count` increments by one (sync error).
      - When `miss` reaches `UNLOCK_COUNT`, the FSM moves to HUNT.
    - At `byte_idx`=1, if `ts_data[7]`=1 (TEI), `error_count` increments by one.
- No errors are counted in HUNT or VERIFY.
- Silence handling:
  - `silence` clears on any `ts_valid` cycle.
  - Otherwise `silence` increments, saturating at `SILENCE_TIMEOUT`.
  - When `silence` reaches `SILENCE_TIMEOUT`, the FSM forces HUNT. This is not counted as an error.
- `signal_present` = (state==LOCKED) and (`silence` < `SILENCE_TIMEOUT`). It is registered.
- Error window:
  - With `reset_timer`≠0, `win_cnt` increments every clock.
  - When `win_cnt` >= `reset_timer`-1, `win_cnt` returns to 0 and `error_count` clears. The >= comparison covers `reset_timer` being lowered while running.
  - With `reset_timer`=0, `win_cnt` is held at 0 and no clearing occurs.
- Arithmetic and simultaneous events:
  - `error_count` saturates at 255. Increments at 255 are discarded.
  - A clear and an error increment in the same cycle produce `error_count`=1.
  - Two increments cannot occur in one cycle, because sync and TEI errors sit at different byte indices.

## Timing
- Reset values: `locked`=0, `signal_present`=0, `error_count`=0, state HUNT, and all counters 0.
- Reset is asynchronous. Assertion mid-packet clears all state immediately, and the first valid byte after release is treated as a HUNT candidate.
- All outputs are registered:
  - `locked` asserts the cycle after the `LOCK_COUNT`-th sync byte is sampled.
  - `error_count` updates the cycle after the erroring byte is sampled.
  - `signal_present` follows `locked` in the same cycle, and drops the cycle after `silence` reaches its limit.
- Gaps in `ts_valid` do not disturb `byte_idx` alignment. Only the silence timeout reacts to them.
- No handshake: the block is a passive monitor with no backpressure.

## Test plan
- **Lock acquisition:** 3 clean 188-byte packets, gap-free -> `locked`=1 and `signal_present`=1 one cycle after the third 0x47; `error_count`=0.
- **TEI counting:** once locked, 5 packets with byte 1 = 0x80 -> `error_count`=5. A packet with byte 1 = 0x80 sent before lock -> no increment.
- **Sync loss:** once locked, corrupt sync to 0x00 in 3 consecutive packets -> `error_count` reaches 3, then `locked`=0. A single corrupted sync followed by a good one -> `locked` stays 1 and `error_count`=1.
- **Window and saturation:**
  - `reset_timer`=0 with 300 TEI packets -> `error_count` holds at 255.
  - `reset_timer`=1000 -> `error_count` returns to 0 every 1000 clocks.
  - An error coinciding with the clear -> `error_count`=1.
- **Silence:** with `SILENCE_TIMEOUT`=100, hold `ts_valid`=0 for 100 clocks while locked -> `signal_present`=0 and `locked`=0. Resume clean packets -> relock after 3 syncs.
- **Reset mid-packet:** assert `rstn`=0 at `byte_idx`=90 while locked with `error_count`=7 -> all outputs 0 immediately. After release, relock requires 3 fresh syncs.
